// File: rtl/collision_con.sv
// Collision and scoring controller: per-tick wall/body/apple checks, score and LFSR apple respawn.
// Optional feature macro: SELF_COLLISION_EN (when defined, bodyHit ends the game).
module collision_con #(
  parameter int          GRID       = 20,
  parameter int          COLS       = 64,
  parameter int          ROWS       = 36,
  parameter int          TOP_Y      = 80,
  parameter int          MAX_POINTS = 16,
  parameter int          APPLE_X0   = 640,
  parameter int          APPLE_Y0   = 400,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [10:0] headX,
  input  logic [10:0] headY,
  input  logic        bodyHit,
  input  logic        restart,
  output logic [5:0]  points,
  output logic [10:0] appleX,
  output logic [10:0] appleY,
  output logic        appleValid,
  output logic        eaten,
  output logic        gameOver,
  output logic        won
);

  typedef enum logic [1:0] {PLAY, RESPAWN, OVER, WIN} state_t;

  localparam logic [11:0] X_MAX  = 12'((COLS - 1) * GRID);
  localparam logic [11:0] Y_MIN  = 12'(TOP_Y);
  localparam logic [11:0] Y_MAX  = 12'(TOP_Y + (ROWS - 1) * GRID);
  localparam logic [6:0]  COLS_L = 7'(COLS);
  localparam logic [6:0]  ROWS_L = 7'(ROWS);
  localparam logic [10:0] GRID_L = 11'(GRID);
  localparam logic [10:0] TOP_L  = 11'(TOP_Y);
  localparam logic [5:0]  MAX_L  = 6'(MAX_POINTS);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  points_q, points_d;
  logic [10:0] apple_x_q, apple_x_d;
  logic [10:0] apple_y_q, apple_y_d;
  logic        apple_valid_q, apple_valid_d;
  logic        eaten_q, eaten_d;
  logic        game_over_q, game_over_d;
  logic        won_q, won_d;
  logic [10:0] head_x_q, head_x_d;
  logic [10:0] head_y_q, head_y_d;

  logic        lfsr_fb;
  logic [5:0]  cand_col, cand_row;
  logic [10:0] cand_x, cand_y;
  logic        accept, wall_hit, self_hit, apple_hit;
  logic [5:0]  points_inc;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand_col = lfsr_q[5:0];
  assign cand_row = lfsr_q[13:8];
  assign cand_x   = 11'(cand_col) * GRID_L;
  assign cand_y   = TOP_L + 11'(cand_row) * GRID_L;

  // A new apple must land inside the field and not under the last known head.
  assign accept = ({1'b0, cand_row} < ROWS_L) && ({1'b0, cand_col} < COLS_L) &&
                  !((cand_x == head_x_q) && (cand_y == head_y_q));

  assign wall_hit  = ({1'b0, headX} > X_MAX) || ({1'b0, headY} < Y_MIN) ||
                     ({1'b0, headY} > Y_MAX);
  assign apple_hit = apple_valid_q && (headX == apple_x_q) && (headY == apple_y_q);
  assign points_inc = points_q + 6'd1;

`ifdef SELF_COLLISION_EN
  assign self_hit = bodyHit;
`else
  logic body_unused;
  assign body_unused = bodyHit;
  assign self_hit    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_fb};
    points_d      = points_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_valid_d = apple_valid_q;
    eaten_d       = 1'b0;
    game_over_d   = game_over_q;
    won_d         = won_q;
    head_x_d      = head_x_q;
    head_y_d      = head_y_q;

    case (state_q)
      PLAY, RESPAWN: begin
        if (tick) begin
          head_x_d = headX;
          head_y_d = headY;
        end
        // A fatal tick overrides both an eat and a same-cycle respawn placement.
        if (tick && (wall_hit || self_hit)) begin
          state_d     = OVER;
          game_over_d = 1'b1;
        end else if (tick && apple_hit) begin
          points_d      = points_inc;
          eaten_d       = 1'b1;
          apple_valid_d = 1'b0;
          state_d       = (points_inc == MAX_L) ? WIN : RESPAWN;
          won_d         = (points_inc == MAX_L);
        end else if (state_q == RESPAWN && accept) begin
          apple_x_d     = cand_x;
          apple_y_d     = cand_y;
          apple_valid_d = 1'b1;
          state_d       = PLAY;
        end
      end
      OVER, WIN: begin
        if (restart) begin
          points_d      = 6'd0;
          game_over_d   = 1'b0;
          won_d         = 1'b0;
          apple_valid_d = 1'b0;
          state_d       = RESPAWN;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= PLAY;
      lfsr_q        <= LFSR_SEED;
      points_q      <= 6'd0;
      apple_x_q     <= 11'(APPLE_X0);
      apple_y_q     <= 11'(APPLE_Y0);
      apple_valid_q <= 1'b1;
      eaten_q       <= 1'b0;
      game_over_q   <= 1'b0;
      won_q         <= 1'b0;
      head_x_q      <= 11'd0;
      head_y_q      <= 11'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      points_q      <= points_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_valid_q <= apple_valid_d;
      eaten_q       <= eaten_d;
      game_over_q   <= game_over_d;
      won_q         <= won_d;
      head_x_q      <= head_x_d;
      head_y_q      <= head_y_d;
    end
  end

  assign points     = points_q;
  assign appleX     = apple_x_q;
  assign appleY     = apple_y_q;
  assign appleValid = apple_valid_q;
  assign eaten      = eaten_q;
  assign gameOver   = game_over_q;
  assign won        = won_q;

endmodule

// File: doc/collision_con.md
# collision_con

Per-step collision and scoring controller for the snake game. On each game-step tick it checks the snake head against the playfield walls, the snake body and the current apple. It maintains the 6-bit `points` count that the scoreboard consumes, and re-places the apple from an on-chip LFSR after each eat. It sits between the snake movement logic (upstream) and the scoreboard/draw logic (downstream).

## Interface
Parameters:
- GRID, 20: cell size in pixels; all positions are multiples of GRID
- COLS, 64: playfield columns; x range 0 .. (COLS-1)*GRID
- ROWS, 36: playfield rows; y range TOP_Y .. TOP_Y+(ROWS-1)*GRID
- TOP_Y, 80: first playfield row in pixels (the scoreboard strip is above it)
- MAX_POINTS, 16: score at which the game is won
- APPLE_X0, 640 / APPLE_Y0, 400: apple position after reset
- LFSR_SEED, 16'hACE1: LFSR reset value (must be non-zero)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-step pulse; head is valid when tick=1
- headX  in  11  snake head x, pixels
- headY  in  11  snake head y, pixels
- bodyHit  in  1  head overlaps a body segment; qualified by tick
- restart  in  1  one-cycle pulse; leaves OVER or WIN
- points  out  6  current score, to scoreboard
- appleX / appleY  out  11 each  current apple position
- appleValid  out  1  apple is placed and drawable
- eaten  out  1  one-cycle pulse, apple consumed
- gameOver  out  1  level, game lost
- won  out  1  level, MAX_POINTS reached

## Operation
- States: PLAY, RESPAWN, OVER, WIN.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in every state.
- Wall hit: headX > (COLS-1)*GRID, or headY < TOP_Y, or headY > TOP_Y+(ROWS-1)*GRID. Compare at 12 bits to avoid overflow.
- Evaluation happens only on tick, in PLAY or RESPAWN. Priority order:
  1. Wall hit or self hit: go to OVER, gameOver=1.
  2. Apple hit (appleValid and head == apple): points+1, eaten=1, appleValid=0. Go to WIN if the new points equals MAX_POINTS, else to RESPAWN.
  3. Otherwise stay in the current state.
- Apple checks are skipped in RESPAWN because appleValid=0.
- RESPAWN, each cycle:
  - Candidate col = lfsr[5:0], row = lfsr[13:8].
  - Accept when row < ROWS, col < COLS, and the candidate differs from the last sampled head position.
  - On accept: appleX = col*GRID, appleY = TOP_Y+row*GRID, appleValid=1, go to PLAY. Otherwise retry next cycle.
  - A tick that hits a wall or the body in the same cycle as an accept wins: the state goes to OVER.
- OVER / WIN: ticks are ignored and all outputs hold. On restart: points=0, gameOver=0, won=0, go to RESPAWN.
- Restart is ignored in PLAY and RESPAWN.
- points never exceeds MAX_POINTS and never wraps.

## Timing
- Reset values: points=0, appleX=APPLE_X0, appleY=APPLE_Y0, appleValid=1, eaten=0, gameOver=0, won=0, state PLAY, lfsr=LFSR_SEED.
- All outputs are registered. Effects of a tick at edge N are visible after edge N+1 (1-cycle latency).
- eaten is high for exactly one cycle, coincident with the points increment.
- Respawn takes at least 1 cycle after the eat cycle. There is no bound on retries; the maximal-length LFSR guarantees termination.
- Asserting reset mid-RESPAWN or mid-OVER returns all outputs to their reset values immediately.

## Configuration
- SELF_COLLISION_EN
  - Defined: bodyHit is evaluated as described above.
  - Undefined: bodyHit is ignored (the port stays present), and only walls end the game.

## Test plan
- Reset: hold rst=0 for 3 cycles, release -> points=0, appleX=640, appleY=400, appleValid=1, gameOver=0, won=0, eaten=0.
- Eat: tick with head=(640,400) -> next cycle points=1, eaten=1 for one cycle, appleValid=0. Then within ≤64 cycles appleValid=1, appleX is a multiple of 20 and ≤1260, and appleY is in 80..780 on a 20-pixel grid.
- Wall: tick with head=(1280,200) -> gameOver=1 and points unchanged. A further tick with head=(640,400) -> no change. restart -> gameOver=0, points=0, state RESPAWN.
- Self: tick with bodyHit=1 and a legal head -> gameOver=1 with SELF_COLLISION_EN defined; no change without it.
- Win: 16 successive eats -> points=16, won=1, appleValid=0. A 17th eat tick -> points stays 16.
- Priority: tick with head=(640,400) and bodyHit=1 (macro defined) -> gameOver=1, eaten=0, points=0. Reset asserted during RESPAWN -> appleValid=1 at (640,400) immediately.
